output_argmax: RTL and testbench

OUTPUT_ARGMAX -- requirements
Module: output_argmax

---
 rtl/output_argmax_pkg.sv | 34 +++
 rtl/output_argmax.sv | 155 +++++++++++++++
 tb/tb_output_argmax.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_argmax_pkg.sv
// -----------------------------------------------------------------------------
// output_argmax_pkg
// Shared types for the network output stage:
//   activation_type  - activation selector used by the layer blocks
//   argmax_state_t   - state encoding of the output_argmax sequencer
//   argmax_index_width() - width of a class index for a given class count
// -----------------------------------------------------------------------------
package output_argmax_pkg;

  typedef enum logic [1:0] {
    ACT_LINEAR  = 2'd0,
    ACT_RELU    = 2'd1,
    ACT_SIGMOID = 2'd2,
    ACT_TANH    = 2'd3
  } activation_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

  // A single-class build still needs a 1-bit index port.
  function automatic int argmax_index_width(input int num_classes);
    int w;
    if (num_classes > 1) begin
      w = $clog2(num_classes);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/output_argmax.sv
// -----------------------------------------------------------------------------
// output_argmax
// Captures one vector of signed class scores and scans it sequentially, one
// element per clock, to find the largest score and its index. Ties resolve to
// the lowest index. The result is held with a valid/ready handshake.
//
// Ports
//   clock        : rising-edge clock
//   reset        : asynchronous, active-low reset
//   inputs_ready : one-cycle pulse, `inputs` valid (accepted only in IDLE)
//   inputs       : NUM_CLASSES signed scores
//   class_index  : index of the maximum score
//   max_value    : maximum score
//   result_valid : result available, held until result_ready
//   result_ready : consumer accepts the result
//   busy         : sequencer is not IDLE
//   overrun      : sticky, a vector arrived while not IDLE and was dropped
// -----------------------------------------------------------------------------
module output_argmax
  import output_argmax_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CLASSES = 2,
  localparam int INDEX_WIDTH = argmax_index_width(NUM_CLASSES)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         inputs_ready,
  input  logic signed [DATA_WIDTH-1:0] inputs [NUM_CLASSES],
  output logic        [INDEX_WIDTH-1:0] class_index,
  output logic signed [DATA_WIDTH-1:0] max_value,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic                         busy,
  output logic                         overrun
);

  argmax_state_t               state_r;
  logic signed [DATA_WIDTH-1:0] buf_r [NUM_CLASSES];
  logic [INDEX_WIDTH-1:0]      scan_cnt_r;
  logic signed [DATA_WIDTH-1:0] run_max_r;
  logic [INDEX_WIDTH-1:0]      run_idx_r;
  logic [INDEX_WIDTH-1:0]      class_index_r;
  logic signed [DATA_WIDTH-1:0] max_value_r;
  logic                        result_valid_r;
  logic                        busy_r;
  logic                        overrun_r;

  logic signed [DATA_WIDTH-1:0] cand_s;
  logic                        greater_s;
  logic                        last_s;
  logic signed [DATA_WIDTH-1:0] next_max_s;
  logic [INDEX_WIDTH-1:0]      next_idx_s;

  // Compare the buffered element under the scan counter against the running max.
  always_comb begin
    cand_s    = buf_r[scan_cnt_r];
    greater_s = (cand_s > run_max_r);
    last_s    = (scan_cnt_r == INDEX_WIDTH'(NUM_CLASSES - 1));
    if (greater_s) begin
      next_max_s = cand_s;
      next_idx_s = scan_cnt_r;
    end else begin
      next_max_s = run_max_r;
      next_idx_s = run_idx_r;
    end
  end

  // Sequencer: capture in IDLE, one comparison per cycle in SCAN, hold in DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      buf_r          <= '{default: '0};
      scan_cnt_r     <= '0;
      run_max_r      <= '0;
      run_idx_r      <= '0;
      class_index_r  <= '0;
      max_value_r    <= '0;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      overrun_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (inputs_ready) begin
            buf_r      <= inputs;
            run_max_r  <= inputs[0];
            run_idx_r  <= '0;
            scan_cnt_r <= INDEX_WIDTH'(1);
            busy_r     <= 1'b1;
            if (NUM_CLASSES == 1) begin
              // Nothing to scan: element 0 is the answer.
              state_r        <= DONE;
              class_index_r  <= '0;
              max_value_r    <= inputs[0];
              result_valid_r <= 1'b1;
            end else begin
              state_r <= SCAN;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          if (inputs_ready) begin
            overrun_r <= 1'b1;
          end else begin
            overrun_r <= overrun_r;
          end
          run_max_r  <= next_max_s;
          run_idx_r  <= next_idx_s;
          scan_cnt_r <= scan_cnt_r + INDEX_WIDTH'(1);
          if (last_s) begin
            // Publish the final comparison directly so the result appears
            // on the same edge the scan completes.
            state_r        <= DONE;
            class_index_r  <= next_idx_s;
            max_value_r    <= next_max_s;
            result_valid_r <= 1'b1;
          end else begin
            state_r <= SCAN;
          end
        end
        DONE: begin
          // A vector arriving here is dropped even if the result is being
          // accepted on the same edge.
          if (inputs_ready) begin
            overrun_r <= 1'b1;
          end else begin
            overrun_r <= overrun_r;
          end
          if (result_ready) begin
            state_r        <= IDLE;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r        <= IDLE;
          result_valid_r <= 1'b0;
          busy_r         <= 1'b0;
        end
      endcase
    end
  end

  assign class_index  = class_index_r;
  assign max_value    = max_value_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_output_argmax.sv
// -----------------------------------------------------------------------------
// tb_output_argmax
// Drives three builds of output_argmax (4, 1 and 2 classes) sharing one clock
// and reset, and compares their results against an argmax reference model.
// -----------------------------------------------------------------------------
module tb_output_argmax;

  typedef logic signed [31:0] vec4_t [4];

  logic clock;
  logic reset;

  // 4-class build
  logic               ir4, rr4, rv4, busy4, ovr4;
  logic signed [31:0] in4 [4];
  logic [1:0]         idx4;
  logic signed [31:0] max4;

  // 1-class build
  logic               ir1, rr1, rv1, busy1, ovr1;
  logic signed [31:0] in1 [1];
  logic [0:0]         idx1;
  logic signed [31:0] max1;

  // 2-class build
  logic               ir2, rr2, rv2, busy2, ovr2;
  logic signed [31:0] in2 [2];
  logic [0:0]         idx2;
  logic signed [31:0] max2;

  int checks;
  int errors;

  output_argmax #(.DATA_WIDTH(32), .NUM_CLASSES(4)) dut4 (
    .clock(clock), .reset(reset), .inputs_ready(ir4), .inputs(in4),
    .class_index(idx4), .max_value(max4), .result_valid(rv4),
    .result_ready(rr4), .busy(busy4), .overrun(ovr4)
  );

  output_argmax #(.DATA_WIDTH(32), .NUM_CLASSES(1)) dut1 (
    .clock(clock), .reset(reset), .inputs_ready(ir1), .inputs(in1),
    .class_index(idx1), .max_value(max1), .result_valid(rv1),
    .result_ready(rr1), .busy(busy1), .overrun(ovr1)
  );

  output_argmax #(.DATA_WIDTH(32), .NUM_CLASSES(2)) dut2 (
    .clock(clock), .reset(reset), .inputs_ready(ir2), .inputs(in2),
    .class_index(idx2), .max_value(max2), .result_valid(rv2),
    .result_ready(rr2), .busy(busy2), .overrun(ovr2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: find the maximum value, then the first position holding it.
  function automatic void ref_argmax(input vec4_t v, output int idx, output logic signed [31:0] mx);
    mx = v[0];
    foreach (v[i]) if (v[i] > mx) mx = v[i];
    idx = -1;
    foreach (v[i]) if (idx < 0 && v[i] == mx) idx = i;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse4(input vec4_t v);
    in4 = v;
    ir4 = 1'b1;
    tick();
    ir4 = 1'b0;
  endtask

  task automatic wait_valid4(output int cyc);
    cyc = 0;
    while (rv4 !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic accept4();
    rr4 = 1'b1;
    tick();
    rr4 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ir4 = 1'b0; rr4 = 1'b0; ir1 = 1'b0; rr1 = 1'b0; ir2 = 1'b0; rr2 = 1'b0;
    in4 = '{default: '0}; in1 = '{default: '0}; in2 = '{default: '0};
    #3;
    checks++;
    if ({rv4, busy4, ovr4} !== 3'b000 || idx4 !== 2'd0 || max4 !== 32'sd0) begin
      errors++;
      $display("FAIL reset4 got rv=%b busy=%b ovr=%b idx=%0d max=%0d want all 0", rv4, busy4, ovr4, idx4, max4);
    end
    checks++;
    if ({rv1, busy1, ovr1} !== 3'b000 || idx1 !== 1'd0 || max1 !== 32'sd0) begin
      errors++;
      $display("FAIL reset1 got rv=%b busy=%b ovr=%b idx=%0d max=%0d want all 0", rv1, busy1, ovr1, idx1, max1);
    end
    checks++;
    if ({rv2, busy2, ovr2} !== 3'b000 || idx2 !== 1'd0 || max2 !== 32'sd0) begin
      errors++;
      $display("FAIL reset2 got rv=%b busy=%b ovr=%b idx=%0d max=%0d want all 0", rv2, busy2, ovr2, idx2, max2);
    end
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_distinct();
    pulse4('{32'sd5, -32'sd3, 32'sd17, 32'sd2});
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) tick();
      checks++;
      if (busy4 !== 1'b1 || rv4 !== (c == 3)) begin
        errors++;
        $display("FAIL distinct_timing edge k+%0d got busy=%b rv=%b want busy=1 rv=%b", c, busy4, rv4, (c == 3));
      end
    end
    checks++;
    if (idx4 !== 2'd2 || max4 !== 32'sd17) begin
      errors++;
      $display("FAIL distinct_result got idx=%0d max=%0d want idx=2 max=17", idx4, max4);
    end
    accept4();
    checks++;
    if (rv4 !== 1'b0 || busy4 !== 1'b0 || idx4 !== 2'd2 || max4 !== 32'sd17) begin
      errors++;
      $display("FAIL distinct_accept got rv=%b busy=%b idx=%0d max=%0d want rv=0 busy=0 idx=2 max=17", rv4, busy4, idx4, max4);
    end
  endtask

  task automatic test_neg_ties();
    int cyc;
    pulse4('{-32'sd8, -32'sd1, -32'sd1, -32'sd20});
    wait_valid4(cyc);
    checks++;
    if (cyc !== 3 || idx4 !== 2'd1 || max4 !== -32'sd1) begin
      errors++;
      $display("FAIL negatives got lat=%0d idx=%0d max=%0d want lat=3 idx=1 max=-1", cyc, idx4, max4);
    end
    accept4();
    pulse4('{32'sd7, 32'sd7, 32'sd7, 32'sd7});
    wait_valid4(cyc);
    checks++;
    if (cyc !== 3 || idx4 !== 2'd0 || max4 !== 32'sd7) begin
      errors++;
      $display("FAIL all_equal got lat=%0d idx=%0d max=%0d want lat=3 idx=0 max=7", cyc, idx4, max4);
    end
    accept4();
  endtask

  task automatic test_random();
    vec4_t v;
    int cyc, eidx, hold;
    logic signed [31:0] emax;
    for (int n = 0; n < 40; n++) begin
      foreach (v[i]) begin
        if ($urandom_range(0, 1) == 1) v[i] = 32'(int'($urandom_range(0, 6)) - 3);
        else v[i] = 32'($urandom);
      end
      ref_argmax(v, eidx, emax);
      pulse4(v);
      // Scramble the live inputs; the captured copy must be used.
      foreach (in4[i]) in4[i] = 32'($urandom);
      wait_valid4(cyc);
      checks++;
      if (cyc !== 3 || idx4 !== 2'(eidx) || max4 !== emax) begin
        errors++;
        $display("FAIL random[%0d] got lat=%0d idx=%0d max=%0d want lat=3 idx=%0d max=%0d", n, cyc, idx4, max4, eidx, emax);
      end
      hold = int'($urandom_range(0, 3));
      for (int j = 0; j < hold; j++) begin
        tick();
        checks++;
        if (rv4 !== 1'b1 || idx4 !== 2'(eidx) || max4 !== emax) begin
          errors++;
          $display("FAIL random_hold[%0d] got rv=%b idx=%0d max=%0d want rv=1 idx=%0d max=%0d", n, rv4, idx4, max4, eidx, emax);
        end
      end
      accept4();
      checks++;
      if (rv4 !== 1'b0 || busy4 !== 1'b0 || ovr4 !== 1'b0) begin
        errors++;
        $display("FAIL random_accept[%0d] got rv=%b busy=%b ovr=%b want 0 0 0", n, rv4, busy4, ovr4);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    pulse4('{32'sd1, 32'sd2, 32'sd3, 32'sd4});
    wait_valid4(cyc);
    checks++;
    if (cyc !== 3 || idx4 !== 2'd3 || max4 !== 32'sd4) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d idx=%0d max=%0d want lat=3 idx=3 max=4", cyc, idx4, max4);
    end
    accept4();
    pulse4('{32'sd0, 32'sd0, 32'sd0, -32'sd5});
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_capture got busy=%b want 1", busy4);
    end
    wait_valid4(cyc);
    checks++;
    if (cyc !== 3 || idx4 !== 2'd0 || max4 !== 32'sd0 || ovr4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d idx=%0d max=%0d ovr=%b want lat=3 idx=0 max=0 ovr=0", cyc, idx4, max4, ovr4);
    end
    accept4();
  endtask

  task automatic test_backpressure();
    int cyc;
    checks++;
    if (ovr4 !== 1'b0) begin
      errors++;
      $display("FAIL bp_pre_overrun got %b want 0", ovr4);
    end
    pulse4('{32'sd5, -32'sd3, 32'sd17, 32'sd2});
    in4 = '{32'sd100, 32'sd0, 32'sd0, 32'sd0};
    ir4 = 1'b1;
    tick();
    ir4 = 1'b0;
    checks++;
    if (ovr4 !== 1'b1 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL bp_overrun got ovr=%b busy=%b want ovr=1 busy=1", ovr4, busy4);
    end
    wait_valid4(cyc);
    checks++;
    if (cyc !== 2 || idx4 !== 2'd2 || max4 !== 32'sd17) begin
      errors++;
      $display("FAIL bp_result got lat=%0d idx=%0d max=%0d want lat=2 idx=2 max=17", cyc, idx4, max4);
    end
    for (int j = 0; j < 10; j++) begin
      tick();
      checks++;
      if (rv4 !== 1'b1 || idx4 !== 2'd2 || max4 !== 32'sd17) begin
        errors++;
        $display("FAIL bp_hold[%0d] got rv=%b idx=%0d max=%0d want rv=1 idx=2 max=17", j, rv4, idx4, max4);
      end
    end
    accept4();
    checks++;
    if (rv4 !== 1'b0 || busy4 !== 1'b0 || ovr4 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got rv=%b busy=%b ovr=%b want 0 0 1", rv4, busy4, ovr4);
    end
  endtask

  task automatic test_reset_midscan();
    int seen;
    pulse4('{32'sd5, -32'sd3, 32'sd17, 32'sd2});
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({rv4, busy4, ovr4} !== 3'b000 || idx4 !== 2'd0 || max4 !== 32'sd0) begin
      errors++;
      $display("FAIL midscan_reset got rv=%b busy=%b ovr=%b idx=%0d max=%0d want all 0", rv4, busy4, ovr4, idx4, max4);
    end
    tick();
    tick();
    reset = 1'b1;
    seen = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (rv4 !== 1'b0 || busy4 !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midscan_quiet got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_done_overrun();
    int cyc;
    pulse4('{32'sd9, 32'sd1, 32'sd2, 32'sd3});
    wait_valid4(cyc);
    checks++;
    if (cyc !== 3 || idx4 !== 2'd0 || max4 !== 32'sd9 || ovr4 !== 1'b0) begin
      errors++;
      $display("FAIL done_ovr_first got lat=%0d idx=%0d max=%0d ovr=%b want lat=3 idx=0 max=9 ovr=0", cyc, idx4, max4, ovr4);
    end
    in4 = '{32'sd100, 32'sd0, 32'sd0, 32'sd0};
    ir4 = 1'b1;
    rr4 = 1'b1;
    tick();
    ir4 = 1'b0;
    rr4 = 1'b0;
    checks++;
    if (ovr4 !== 1'b1 || rv4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL done_ovr got ovr=%b rv=%b busy=%b want ovr=1 rv=0 busy=0", ovr4, rv4, busy4);
    end
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++;
      if (rv4 !== 1'b0 || busy4 !== 1'b0 || max4 !== 32'sd9) begin
        errors++;
        $display("FAIL done_ovr_drop[%0d] got rv=%b busy=%b max=%0d want rv=0 busy=0 max=9", j, rv4, busy4, max4);
      end
    end
  endtask

  task automatic test_single_class();
    in1[0] = -32'sd42;
    ir1 = 1'b1;
    tick();
    ir1 = 1'b0;
    checks++;
    if (rv1 !== 1'b1 || busy1 !== 1'b1 || idx1 !== 1'd0 || max1 !== -32'sd42) begin
      errors++;
      $display("FAIL n1_result got rv=%b busy=%b idx=%0d max=%0d want rv=1 busy=1 idx=0 max=-42", rv1, busy1, idx1, max1);
    end
    rr1 = 1'b1;
    tick();
    rr1 = 1'b0;
    checks++;
    if (rv1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL n1_accept got rv=%b busy=%b want 0 0", rv1, busy1);
    end
  endtask

  task automatic test_two_class();
    in2 = '{32'sd3, 32'sd9};
    ir2 = 1'b1;
    tick();
    ir2 = 1'b0;
    checks++;
    if (rv2 !== 1'b0 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL n2_scan got rv=%b busy=%b want rv=0 busy=1", rv2, busy2);
    end
    tick();
    checks++;
    if (rv2 !== 1'b1 || idx2 !== 1'd1 || max2 !== 32'sd9) begin
      errors++;
      $display("FAIL n2_result got rv=%b idx=%0d max=%0d want rv=1 idx=1 max=9", rv2, idx2, max2);
    end
    rr2 = 1'b1;
    tick();
    rr2 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_distinct();
    test_neg_ties();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_midscan();
    test_done_overrun();
    test_single_class();
    test_two_class();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
